// File: rtl/bbscan_pkg.sv
// Shared types and defaults for the blackbox truth-table scanner.
package bbscan_pkg;

    // Scan sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StFinish
    } state_e;

    localparam int unsigned NInDefault    = 3;
    localparam logic [7:0]  GoldenDefault = 8'h45;
    // Settle counter width; covers SETTLE values 0..15
    localparam int unsigned SettleW       = 4;

endpackage

// File: rtl/bbscan_popcnt.sv
// Combinational mismatch statistics for a captured truth table:
// popcount of the difference vector, plus the lowest set index when
// BBSCAN_FIRST_ERR_EN is defined.
module bbscan_popcnt
    import bbscan_pkg::*;
#(
    parameter int unsigned N_IN = NInDefault
) (
    input  logic [2**N_IN-1:0] diff_i,
    output logic [N_IN:0]      cnt_o
`ifdef BBSCAN_FIRST_ERR_EN
    ,
    output logic               first_vld_o,
    output logic [N_IN-1:0]    first_idx_o
`endif
);

    localparam int unsigned Width = 2**N_IN;

    // Count differing table entries
    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < int'(Width); k++) begin
            cnt_o = cnt_o + (N_IN+1)'(diff_i[k]);
        end
    end

`ifdef BBSCAN_FIRST_ERR_EN
    // Scan high to low so the lowest differing index wins
    always_comb begin
        first_vld_o = 1'b0;
        first_idx_o = '0;
        for (int k = int'(Width) - 1; k >= 0; k--) begin
            if (diff_i[k]) begin
                first_vld_o = 1'b1;
                first_idx_o = N_IN'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/blackbox_tt_scanner.sv
// Truth-table scanner for a small combinational blackbox. Drives every input
// vector, waits SETTLE cycles, samples the output, then compares the captured
// table against GOLDEN. Optional macro BBSCAN_FIRST_ERR_EN adds the
// first_err_vld_o/first_err_idx_o outputs.
module blackbox_tt_scanner
    import bbscan_pkg::*;
#(
    parameter int unsigned       N_IN   = NInDefault,
    parameter int unsigned       SETTLE = 1,
    parameter logic [2**N_IN-1:0] GOLDEN = GoldenDefault
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic [N_IN-1:0]      dut_in_o,
    input  logic                 dut_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2**N_IN-1:0]   tt_o,
    output logic                 tt_valid_o,
    output logic                 match_o,
    output logic [N_IN:0]        err_cnt_o
`ifdef BBSCAN_FIRST_ERR_EN
    ,
    output logic                 first_err_vld_o,
    output logic [N_IN-1:0]      first_err_idx_o
`endif
);

    localparam logic [N_IN:0]       LastIdx    = (N_IN+1)'(2**N_IN - 1);
    localparam logic [SettleW-1:0]  SettleLoad = SettleW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_e               state_q;
    logic [N_IN:0]        idx_q;
    logic [SettleW-1:0]   cnt_q;
    logic [N_IN-1:0]      dut_in_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2**N_IN-1:0]   tt_q;
    logic                 tt_valid_q;
    logic                 match_q;
    logic [N_IN:0]        err_cnt_q;
    logic [N_IN:0]        diff_cnt;

`ifdef BBSCAN_FIRST_ERR_EN
    logic                 diff_first_vld;
    logic [N_IN-1:0]      diff_first_idx;
    logic                 first_err_vld_q;
    logic [N_IN-1:0]      first_err_idx_q;
`endif

    bbscan_popcnt #(
        .N_IN (N_IN)
    ) u_popcnt (
        .diff_i      (tt_q ^ GOLDEN),
        .cnt_o       (diff_cnt)
`ifdef BBSCAN_FIRST_ERR_EN
        ,
        .first_vld_o (diff_first_vld),
        .first_idx_o (diff_first_idx)
`endif
    );

    // Scan sequencer with registered outputs; abort overrides every transition
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            match_q    <= 1'b0;
            err_cnt_q  <= '0;
`ifdef BBSCAN_FIRST_ERR_EN
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && abort_i) begin
                // Drop the partial scan; tt keeps its bits but is no longer valid
                state_q    <= StIdle;
                busy_q     <= 1'b0;
                dut_in_q   <= '0;
                tt_valid_q <= 1'b0;
                match_q    <= 1'b0;
                err_cnt_q  <= '0;
`ifdef BBSCAN_FIRST_ERR_EN
                first_err_vld_q <= 1'b0;
                first_err_idx_q <= '0;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i && !abort_i) begin
                            idx_q      <= '0;
                            tt_q       <= '0;
                            tt_valid_q <= 1'b0;
                            match_q    <= 1'b0;
                            err_cnt_q  <= '0;
`ifdef BBSCAN_FIRST_ERR_EN
                            first_err_vld_q <= 1'b0;
                            first_err_idx_q <= '0;
`endif
                            busy_q     <= 1'b1;
                            state_q    <= StDrive;
                        end
                    end
                    StDrive: begin
                        dut_in_q <= idx_q[N_IN-1:0];
                        cnt_q    <= SettleLoad;
                        state_q  <= (SETTLE == 0) ? StSample : StSettle;
                    end
                    StSettle: begin
                        if (cnt_q == '0) begin
                            state_q <= StSample;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StSample: begin
                        tt_q[idx_q[N_IN-1:0]] <= dut_out_i;
                        if (idx_q == LastIdx) begin
                            state_q <= StFinish;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StDrive;
                        end
                    end
                    StFinish: begin
                        done_q     <= 1'b1;
                        tt_valid_q <= 1'b1;
                        match_q    <= (diff_cnt == '0);
                        err_cnt_q  <= diff_cnt;
`ifdef BBSCAN_FIRST_ERR_EN
                        first_err_vld_q <= diff_first_vld;
                        first_err_idx_q <= diff_first_idx;
`endif
                        busy_q     <= 1'b0;
                        dut_in_q   <= '0;
                        state_q    <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign dut_in_o   = dut_in_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign tt_o       = tt_q;
    assign tt_valid_o = tt_valid_q;
    assign match_o    = match_q;
    assign err_cnt_o  = err_cnt_q;
`ifdef BBSCAN_FIRST_ERR_EN
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_idx_o = first_err_idx_q;
`endif

endmodule

// File: tb/tb_blackbox_tt_scanner.sv
// Bench for blackbox_tt_scanner: three instances (SETTLE = 1, 0, 3) share
// start/abort/reset and each drives its own copy of a modelled blackbox.
module tb_blackbox_tt_scanner;

    localparam logic [7:0] GOLD = 8'h45;

    logic clk;
    logic reset;
    logic start;
    logic abort;
    int   bb_mode;
    logic [7:0] bb_tt;

    logic [2:0] din_w   [3];
    logic       dout_w  [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] tt_w    [3];
    logic       ttv_w   [3];
    logic       match_w [3];
    logic [3:0] err_w   [3];
`ifdef BBSCAN_FIRST_ERR_EN
    logic       fev_w   [3];
    logic [2:0] fei_w   [3];
`endif

    // Blackbox behaviour: 0 = golden formula, 1 = stuck-at-1, else lookup table
    function automatic logic bb_fn(int mode, logic [7:0] tbl, logic [2:0] x);
        logic i, h, o;
        {i, h, o} = x;
        if (mode == 0) return ~o & (~i | h);
        if (mode == 1) return 1'b1;
        return tbl[x];
    endfunction

    assign dout_w[0] = bb_fn(bb_mode, bb_tt, din_w[0]);
    assign dout_w[1] = bb_fn(bb_mode, bb_tt, din_w[1]);
    assign dout_w[2] = bb_fn(bb_mode, bb_tt, din_w[2]);

    blackbox_tt_scanner #(.N_IN(3), .SETTLE(1), .GOLDEN(GOLD)) u_dut_s1 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .dut_in_o(din_w[0]), .dut_out_i(dout_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .tt_o(tt_w[0]), .tt_valid_o(ttv_w[0]), .match_o(match_w[0]), .err_cnt_o(err_w[0])
`ifdef BBSCAN_FIRST_ERR_EN
        , .first_err_vld_o(fev_w[0]), .first_err_idx_o(fei_w[0])
`endif
    );

    blackbox_tt_scanner #(.N_IN(3), .SETTLE(0), .GOLDEN(GOLD)) u_dut_s0 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .dut_in_o(din_w[1]), .dut_out_i(dout_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .tt_o(tt_w[1]), .tt_valid_o(ttv_w[1]), .match_o(match_w[1]), .err_cnt_o(err_w[1])
`ifdef BBSCAN_FIRST_ERR_EN
        , .first_err_vld_o(fev_w[1]), .first_err_idx_o(fei_w[1])
`endif
    );

    blackbox_tt_scanner #(.N_IN(3), .SETTLE(3), .GOLDEN(GOLD)) u_dut_s3 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .dut_in_o(din_w[2]), .dut_out_i(dout_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
        .tt_o(tt_w[2]), .tt_valid_o(ttv_w[2]), .match_o(match_w[2]), .err_cnt_o(err_w[2])
`ifdef BBSCAN_FIRST_ERR_EN
        , .first_err_vld_o(fev_w[2]), .first_err_idx_o(fei_w[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Each vector occupies P = 2 + SETTLE cycles. Counting edges e from the
    // accepting edge (e = 0): vector v is on dut_in for e in [v*P+1, (v+1)*P],
    // it is sampled at e = (v+1)*P, and done follows at e = 8*P + 1.
    int         per [3] = '{3, 2, 5};
    int         m_e     [3];
    bit         m_act   [3];
    logic [2:0] m_din   [3];
    bit         m_busy  [3];
    bit         m_done  [3];
    logic [7:0] m_tt    [3];
    bit         m_ttv   [3];
    bit         m_match [3];
    logic [3:0] m_err   [3];
    bit         m_fev   [3];
    logic [2:0] m_fei   [3];

    task automatic model_reset(int n);
        m_e[n] = 0; m_act[n] = 0; m_din[n] = '0; m_busy[n] = 0; m_done[n] = 0;
        m_tt[n] = '0; m_ttv[n] = 0; m_match[n] = 0; m_err[n] = '0;
        m_fev[n] = 0; m_fei[n] = '0;
    endtask

    task automatic model_clear_result(int n);
        m_ttv[n] = 0; m_match[n] = 0; m_err[n] = '0; m_fev[n] = 0; m_fei[n] = '0;
    endtask

    task automatic model_step(int n);
        int p;
        int e;
        int v;
        p = per[n];
        m_done[n] = 0;
        if (m_act[n]) begin
            if (abort) begin
                m_act[n] = 0; m_busy[n] = 0; m_din[n] = '0;
                model_clear_result(n);
            end else begin
                m_e[n] = m_e[n] + 1;
                e = m_e[n];
                if (e <= 8 * p) begin
                    m_din[n] = 3'((e - 1) / p);
                    if (e % p == 0) begin
                        v = e / p - 1;
                        m_tt[n][v] = bb_fn(bb_mode, bb_tt, 3'(v));
                    end
                end else begin
                    m_act[n] = 0; m_busy[n] = 0; m_done[n] = 1; m_din[n] = '0;
                    m_ttv[n] = 1;
                    m_err[n] = '0; m_fev[n] = 0; m_fei[n] = '0;
                    for (int k = 0; k < 8; k++) begin
                        if (m_tt[n][k] != GOLD[k]) begin
                            m_err[n] = m_err[n] + 1'b1;
                            if (!m_fev[n]) begin
                                m_fev[n] = 1;
                                m_fei[n] = 3'(k);
                            end
                        end
                    end
                    m_match[n] = (m_err[n] == 0);
                end
            end
        end else if (start && !abort) begin
            m_act[n] = 1; m_e[n] = 0; m_busy[n] = 1; m_tt[n] = '0;
            model_clear_result(n);
        end
    endtask

    int edge_cnt = 0;
    int acc_edge = 0;
    int done_edge [3];

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        for (int n = 0; n < 3; n++) begin
            if (reset) model_reset(n);
            else model_step(n);
        end
    end

    always @(posedge reset) begin
        for (int n = 0; n < 3; n++) model_reset(n);
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, n, $time, act, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // Cycle-by-cycle compare against the model, plus done-latency recording
    always @(negedge clk) begin
        if (!reset) begin
            for (int n = 0; n < 3; n++) begin
                chk("dut_in",   n, 32'(din_w[n]),   32'(m_din[n]));
                chk("busy",     n, 32'(busy_w[n]),  32'(m_busy[n]));
                chk("done",     n, 32'(done_w[n]),  32'(m_done[n]));
                chk("tt",       n, 32'(tt_w[n]),    32'(m_tt[n]));
                chk("tt_valid", n, 32'(ttv_w[n]),   32'(m_ttv[n]));
                chk("match",    n, 32'(match_w[n]), 32'(m_match[n]));
                chk("err_cnt",  n, 32'(err_w[n]),   32'(m_err[n]));
`ifdef BBSCAN_FIRST_ERR_EN
                chk("first_vld", n, 32'(fev_w[n]),  32'(m_fev[n]));
                chk("first_idx", n, 32'(fei_w[n]),  32'(m_fei[n]));
`endif
                if (done_w[n] === 1'b1 && done_edge[n] < 0) begin
                    done_edge[n] = edge_cnt - acc_edge;
                end
            end
        end
    end

    task automatic tick(int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic start_scan();
        for (int n = 0; n < 3; n++) done_edge[n] = -1;
        start = 1'b1;
        acc_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"},  0, 32'(busy_w[0]),  0);
        chk({tag, "_done"},  0, 32'(done_w[0]),  0);
        chk({tag, "_din"},   0, 32'(din_w[0]),   0);
        chk({tag, "_tt"},    0, 32'(tt_w[0]),    0);
        chk({tag, "_ttv"},   0, 32'(ttv_w[0]),   0);
        chk({tag, "_match"}, 0, 32'(match_w[0]), 0);
        chk({tag, "_err"},   0, 32'(err_w[0]),   0);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) done_edge[n] = -1;
        reset = 1'b1; start = 1'b0; abort = 1'b0; bb_mode = 0; bb_tt = '0;
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);

        // Golden blackbox: latencies 25/17/41, table 8'h45
        bb_mode = 0;
        start_scan();
        tick(45);
        chk("lat_s1", 0, 32'(done_edge[0]), 25);
        chk("lat_s0", 1, 32'(done_edge[1]), 17);
        chk("lat_s3", 2, 32'(done_edge[2]), 41);
        chk("gold_tt",    0, 32'(tt_w[0]),    32'h45);
        chk("gold_match", 0, 32'(match_w[0]), 1);
        chk("gold_err",   0, 32'(err_w[0]),   0);
        chk("gold_ttv",   0, 32'(ttv_w[0]),   1);

        // Stuck-at-1 blackbox
        bb_mode = 1;
        start_scan();
        tick(45);
        chk("stuck_tt",    2, 32'(tt_w[2]),    32'hFF);
        chk("stuck_match", 0, 32'(match_w[0]), 0);
        chk("stuck_err",   0, 32'(err_w[0]),   5);
`ifdef BBSCAN_FIRST_ERR_EN
        chk("stuck_first", 0, 32'(fei_w[0]),   1);
`endif

        // Abort while SAMPLE of vector 4 is pending (SETTLE=1 instance)
        bb_mode = 0;
        start_scan();
        tick(14);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", 0, 32'(busy_w[0]), 0);
        chk("abort_din",  0, 32'(din_w[0]),  0);
        chk("abort_ttv",  0, 32'(ttv_w[0]),  0);
        tick(30);
        chk("abort_nodone", 0, 32'(done_edge[0]), 32'hFFFF_FFFF);
        start_scan();
        tick(45);
        chk("rescan_lat", 0, 32'(done_edge[0]), 25);
        chk("rescan_tt",  0, 32'(tt_w[0]),      32'h45);

        // Second start mid-scan is ignored
        start_scan();
        tick(9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(40);
        chk("restart_lat", 0, 32'(done_edge[0]), 25);
        chk("restart_busy", 0, 32'(busy_w[0]), 0);

        // start together with abort in idle: nothing starts
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        tick(2);
        chk("start_abort_busy", 0, 32'(busy_w[0]), 0);

        // Async reset mid-SETTLE
        start_scan();
        tick(4);
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        tick(5);
        chk("post_rst_busy", 0, 32'(busy_w[0]), 0);

        // Randomised traffic; blackbox only swapped while every instance is idle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            if (!m_act[0] && !m_act[1] && !m_act[2] && $urandom_range(0, 3) == 0) begin
                bb_mode = int'($urandom_range(0, 2));
                bb_tt   = 8'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        tick(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
